integ_dump_ctrl: RTL and testbench

INTEG_DUMP_CTRL -- requirements
Module: integ_dump_ctrl

---
 rtl/integ_dump_pkg.sv | 27 ++
 rtl/integ_dump_ctrl_if.sv | 33 +++
 rtl/integ_dump_sat.sv | 38 +++
 rtl/integ_dump_ctrl.sv | 150 +++++++++++++++
 tb/tb_integ_dump_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/integ_dump_pkg.sv
// Shared definitions for the integrate-and-dump controller.
// Holds the FSM state encoding, datapath widths and a helper that turns the
// 8-bit length field into a sample count (0 encodes a full 256-sample dump).
package integ_dump_pkg;

    localparam int DATA_W    = 9;
    localparam int ACC_W     = 17;
    localparam int LEN_W     = 8;
    localparam int SHIFT_W   = 4;
    localparam int SHIFT_MAX = 8;
    localparam int CNT_W     = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_e;

    // len == 0 means 256 samples, which needs the extra counter bit.
    function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return {1'b1, {LEN_W{1'b0}}};
        end
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/integ_dump_ctrl_if.sv
// Bus bundle for the integrate-and-dump controller.
// master: job control, sample stream source and result sink (the user side).
// slave : the controller itself.
// Signals: start/len/shift/cont/abort (job control), in_valid/in_data/in_ready
// (sample stream), out_valid/out_data/out_sat/out_ready (result stream), busy.
interface integ_dump_ctrl_if;
    import integ_dump_pkg::*;

    logic                      start;
    logic [LEN_W-1:0]          len;
    logic [SHIFT_W-1:0]        shift;
    logic                      cont;
    logic                      abort;
    logic                      in_valid;
    logic signed [DATA_W-1:0]  in_data;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [DATA_W-1:0]  out_data;
    logic                      out_sat;
    logic                      busy;

    modport master (
        output start, len, shift, cont, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, len, shift, cont, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );

endinterface

// File: rtl/integ_dump_sat.sv
// Combinational shift-and-saturate for the dump result.
// Ports: acc_i   - 17-bit signed accumulator value
//        shift_i - arithmetic right shift amount, anything above 8 acts as 8
//        data_o  - 9-bit signed result clamped to [-256, +255]
//        sat_o   - high when clamping changed the value
module integ_dump_sat
    import integ_dump_pkg::*;
(
    input  logic signed [ACC_W-1:0]   acc_i,
    input  logic [SHIFT_W-1:0]        shift_i,
    output logic signed [DATA_W-1:0]  data_o,
    output logic                      sat_o
);

    localparam int OUT_MAX = 2 ** (DATA_W - 1) - 1;
    localparam int OUT_MIN = -(2 ** (DATA_W - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(OUT_MIN);

    logic [SHIFT_W-1:0]       shift_eff;
    logic signed [ACC_W-1:0]  shifted;

    always_comb begin
        shift_eff = (shift_i > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : shift_i;
        shifted   = acc_i >>> shift_eff;
        if (shifted > SAT_HI) begin
            data_o = SAT_HI[DATA_W-1:0];
            sat_o  = 1'b1;
        end else if (shifted < SAT_LO) begin
            data_o = SAT_LO[DATA_W-1:0];
            sat_o  = 1'b1;
        end else begin
            data_o = shifted[DATA_W-1:0];
            sat_o  = 1'b0;
        end
    end

endmodule

// File: rtl/integ_dump_ctrl.sv
// Integrate-and-dump controller.
// Accumulates a job of len signed samples (0 = 256), then presents the sum
// shifted right by the latched shift and saturated to 9 bits. In continuous
// mode the job restarts automatically after each result handshake.
// Ports: clk    - sole clock, rising edge
//        resetb - asynchronous active-low reset
//        bus    - slave side of integ_dump_ctrl_if (control, samples, result)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; no samples taken, no result offered
// ACCUM | taking samples, counter counts down to the last one
// DUMP  | result held on out_data/out_sat until the consumer takes it
module integ_dump_ctrl
    import integ_dump_pkg::*;
(
    input  logic               clk,
    input  logic               resetb,
    integ_dump_ctrl_if.slave   bus
);

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      cont_q, cont_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      in_ready;
    logic                      out_valid;
    logic                      busy;
    logic                      sample_ok;
    logic                      last_sample;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [DATA_W-1:0]  sat_data;
    logic                      sat_flag;

    assign sample_ok   = bus.in_valid & in_ready;
    assign last_sample = sample_ok & (cnt_q == CNT_W'(1));
    assign acc_sum     = acc_q + {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};

    // Saturation looks at the sum including the current sample so the result
    // can be registered in the same cycle the last sample is accepted.
    integ_dump_sat u_sat (
        .acc_i   (acc_sum),
        .shift_i (shift_q),
        .data_o  (sat_data),
        .sat_o   (sat_flag)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.start) state_d = ACCUM;
                ACCUM:   if (last_sample) state_d = DUMP;
                DUMP:    if (bus.out_ready) state_d = cont_q ? ACCUM : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DUMP);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        cont_d     = cont_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (bus.abort) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_d   = '0;
                        cnt_d   = len_to_count(bus.len);
                        len_d   = bus.len;
                        shift_d = bus.shift;
                        cont_d  = bus.cont;
                    end
                end
                ACCUM: begin
                    if (sample_ok) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (last_sample) begin
                        out_data_d = sat_data;
                        out_sat_d  = sat_flag;
                    end
                end
                DUMP: begin
                    if (bus.out_ready && cont_q) begin
                        acc_d = '0;
                        cnt_d = len_to_count(len_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            cont_q     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            cont_q     <= cont_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_integ_dump_ctrl.sv
// Self-checking bench for integ_dump_ctrl: a table of directed jobs, a few
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_integ_dump_ctrl;
    import integ_dump_pkg::*;

    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    integ_dump_ctrl_if bus ();

    integ_dump_ctrl dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int len;
        int shift;
        int s0, s1, s2, s3;
        int fill;
        int exp_data;
        int exp_sat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Dump value as floor(sum / 2^shift) clamped to 9-bit signed range.
    function automatic void ref_dump(input int sum, input int sh, output int val, output bit sat);
        int eff, d, q;
        eff = (sh > 8) ? 8 : sh;
        d   = 1 << eff;
        q   = sum / d;
        if (sum < 0 && q * d != sum) q = q - 1;
        val = q;
        sat = 1'b0;
        if (q > 255) begin
            val = 255;
            sat = 1'b1;
        end else if (q < -256) begin
            val = -256;
            sat = 1'b1;
        end
    endfunction

    function automatic int sample_of(input vec_t v, input int i);
        case (i)
            0: return v.s0;
            1: return v.s1;
            2: return v.s2;
            3: return v.s3;
            default: return v.fill;
        endcase
    endfunction

    function automatic int odata();
        return int'($signed(bus.out_data));
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.shift     = '0;
        bus.cont      = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic send_start(input int ln, input int sh, input bit ct);
        bus.start = 1'b1;
        bus.len   = 8'(ln);
        bus.shift = 4'(sh);
        bus.cont  = ct;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_sample(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = 9'(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        n = (v.len == 0) ? 256 : v.len;
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), int'(bus.busy), 0);
        send_start(v.len, v.shift, 1'b0);
        check($sformatf("v%0d_accum_in_ready", idx), int'(bus.in_ready), 1);
        check($sformatf("v%0d_accum_busy", idx), int'(bus.busy), 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) check($sformatf("v%0d_early_valid", idx), int'(bus.out_valid), 0);
            send_sample(sample_of(v, i));
        end
        check($sformatf("v%0d_out_valid", idx), int'(bus.out_valid), 1);
        check($sformatf("v%0d_out_data", idx), odata(), v.exp_data);
        check($sformatf("v%0d_out_sat", idx), int'(bus.out_sat), v.exp_sat);
        check($sformatf("v%0d_dump_in_ready", idx), int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check($sformatf("v%0d_after_valid", idx), int'(bus.out_valid), 0);
        check($sformatf("v%0d_after_busy", idx), int'(bus.busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum, acc_n, ev, iv, d;
        bit es;

        vecs[0] = '{4, 0, 10, 20, -5, 7, 0, 32, 0};
        vecs[1] = '{0, 8, 255, 255, 255, 255, 255, 255, 0};
        vecs[2] = '{0, 0, 255, 255, 255, 255, 255, 255, 1};
        vecs[3] = '{0, 0, -256, -256, -256, -256, -256, -256, 1};
        vecs[4] = '{1, 0, -256, 0, 0, 0, 0, -256, 0};
        vecs[5] = '{2, 15, 255, 1, 0, 0, 0, 1, 0};
        vecs[6] = '{3, 1, -1, -1, -1, 0, 0, -2, 0};
        vecs[7] = '{4, 2, 100, 100, 100, 100, 0, 100, 0};
        vecs[8] = '{2, 0, 200, 100, 0, 0, 0, 255, 1};
        vecs[9] = '{0, 9, -256, -256, -256, -256, -256, -256, 0};

        idle_inputs();
        resetb = 1'b1;
        #2 resetb = 1'b0;
        #1;
        check("por_busy", int'(bus.busy), 0);
        check("por_out_valid", int'(bus.out_valid), 0);
        check("por_in_ready", int'(bus.in_ready), 0);
        check("por_out_data", odata(), 0);
        check("por_out_sat", int'(bus.out_sat), 0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Reset in the middle of a job.
        @(negedge clk);
        send_start(5, 0, 1'b0);
        send_sample(50);
        send_sample(60);
        resetb = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_data", odata(), 0);
        check("rst_out_sat", int'(bus.out_sat), 0);
        @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 9'(7);
            @(negedge clk);
            check("rst_no_valid", int'(bus.out_valid), 0);
            check("rst_stay_idle", int'(bus.busy), 0);
        end
        bus.in_valid = 1'b0;

        // Gapped input and held-off output.
        send_start(3, 0, 1'b0);
        sum   = 0;
        acc_n = 0;
        for (int c = 0; c < 100 && acc_n < 3; c++) begin
            check("bp_in_ready", int'(bus.in_ready), 1);
            iv = $urandom_range(0, 1);
            d  = int'($urandom_range(0, 511)) - 256;
            bus.in_valid = iv[0];
            bus.in_data  = 9'(d);
            if (iv != 0) begin
                sum += d;
                acc_n++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", acc_n, 3);
        ref_dump(sum, 0, ev, es);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_data", odata(), ev);
            check("bp_hold_sat", int'(bus.out_sat), int'(es));
            check("bp_hold_in_ready", int'(bus.in_ready), 0);
            bus.in_valid = 1'b1;
            bus.in_data  = 9'(100);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_single_result", int'(bus.out_valid), 0);
            @(negedge clk);
        end

        // Continuous mode with a start during ACCUM that must be ignored.
        send_start(2, 0, 1'b1);
        bus.start = 1'b1;
        bus.len   = 8'(7);
        bus.shift = 4'(3);
        bus.cont  = 1'b0;
        send_sample(1);
        bus.start = 1'b0;
        send_sample(2);
        check("cont_r1_valid", int'(bus.out_valid), 1);
        check("cont_r1_data", odata(), 3);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("cont_reload_in_ready", int'(bus.in_ready), 1);
        check("cont_reload_valid", int'(bus.out_valid), 0);
        send_sample(3);
        check("cont_r2_early", int'(bus.out_valid), 0);
        send_sample(4);
        check("cont_r2_valid", int'(bus.out_valid), 1);
        check("cont_r2_data", odata(), 7);
        // Abort together with the output handshake.
        bus.out_ready = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        check("abort_hs_busy", int'(bus.busy), 0);
        check("abort_hs_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_hs_no_valid", int'(bus.out_valid), 0);
            @(negedge clk);
        end

        // Abort together with start in IDLE.
        bus.abort = 1'b1;
        send_start(1, 0, 1'b0);
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_start_idle", int'(bus.busy), 0);
            @(negedge clk);
        end

        // Abort mid-ACCUM discards the partial sum.
        send_start(3, 0, 1'b0);
        send_sample(100);
        send_sample(100);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_acc_busy", int'(bus.busy), 0);
        send_start(1, 0, 1'b0);
        send_sample(5);
        check("abort_acc_fresh_valid", int'(bus.out_valid), 1);
        check("abort_acc_fresh_data", odata(), 5);
        bus.out_ready = 1'b1;
        @(negedge clk);
        idle_inputs();

        // Randomized run against a transaction-level model.
        begin
            int ph, m_n, m_sh, m_data;
            bit m_cont, m_sat;
            int q[$];
            int ln, sh, s;
            bit st, ab, ct, vi, ordy;
            ph = 0;
            m_n = 0; m_sh = 0; m_data = 0;
            m_cont = 1'b0; m_sat = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                check("rnd_in_ready", int'(bus.in_ready), int'(ph == 1));
                check("rnd_out_valid", int'(bus.out_valid), int'(ph == 2));
                check("rnd_busy", int'(bus.busy), int'(ph != 0));
                if (ph == 2) begin
                    check("rnd_out_data", odata(), m_data);
                    check("rnd_out_sat", int'(bus.out_sat), int'(m_sat));
                end
                st   = ($urandom_range(0, 3) == 0);
                ab   = ($urandom_range(0, 49) == 0);
                ln   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
                sh   = int'($urandom_range(0, 15));
                ct   = 1'($urandom_range(0, 1));
                vi   = 1'($urandom_range(0, 1));
                ordy = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 5))
                    0:       d = 255;
                    1:       d = -256;
                    default: d = int'($urandom_range(0, 511)) - 256;
                endcase
                bus.start     = st;
                bus.abort     = ab;
                bus.len       = 8'(ln);
                bus.shift     = 4'(sh);
                bus.cont      = ct;
                bus.in_valid  = vi;
                bus.in_data   = 9'(d);
                bus.out_ready = ordy;
                if (ab) begin
                    ph = 0;
                    q.delete();
                end else begin
                    case (ph)
                        0: if (st) begin
                            ph = 1;
                            m_n = (ln == 0) ? 256 : ln;
                            m_sh = sh;
                            m_cont = ct;
                            q.delete();
                        end
                        1: if (vi) begin
                            q.push_back(d);
                            if (q.size() == m_n) begin
                                s = 0;
                                for (int k = 0; k < q.size(); k++) s += q[k];
                                ref_dump(s, m_sh, m_data, m_sat);
                                ph = 2;
                            end
                        end
                        default: if (ordy) begin
                            if (m_cont) begin
                                ph = 1;
                                q.delete();
                            end else begin
                                ph = 0;
                            end
                        end
                    endcase
                end
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
